// File: rtl/gate_check_seq_pkg.sv
// Shared encodings for the gate exerciser: op codes, FSM states and the
// expected two-input gate truth function.
package gate_check_seq_pkg;

  typedef enum logic [2:0] {
    OP_AND  = 3'd0,
    OP_OR   = 3'd1,
    OP_XOR  = 3'd2,
    OP_NAND = 3'd3,
    OP_NOR  = 3'd4,
    OP_XNOR = 3'd5
  } op_e;

  // Codes above this are reserved and rejected at start.
  localparam logic [2:0] OP_LAST = 3'd5;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_APPLY  = 3'd1,
    ST_WAIT   = 3'd2,
    ST_SAMPLE = 3'd3,
    ST_DONE   = 3'd4
  } state_e;

  localparam logic [1:0] LAST_VEC = 2'd3;

  function automatic logic gate_exp(input logic [2:0] op, input logic a, input logic b);
    logic y;
    y = 1'b0;
    case (op)
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_XOR:  y = a ^ b;
      OP_NAND: y = ~(a & b);
      OP_NOR:  y = ~(a | b);
      OP_XNOR: y = ~(a ^ b);
      default: y = 1'b0;
    endcase
    return y;
  endfunction

endpackage

// File: rtl/gate_check_seq_gate_ref_model.sv
// Combinational expected-output lookup for the basic two-input gates.
// Reserved op codes yield 0.
module gate_ref_model
  import gate_check_seq_pkg::*;
(
  input  logic [2:0] op,
  input  logic       a,
  input  logic       b,
  output logic       y
);

  assign y = gate_exp(op, a, b);

endmodule

// File: rtl/gate_check_seq.sv
// Gate exerciser: steps {a,b} through 00,01,10,11, waits a settle time per
// vector, compares the gate output against the reference and reports results.
//
// state  | meaning
// IDLE   | waiting for start; reserved op pulses cfg_err
// APPLY  | drive vector vec_idx onto a/b, load hold timer
// WAIT   | settle; down-counter runs to terminal count 0
// SAMPLE | compare y_i with expected, advance vector
// DONE   | one-cycle done pulse, return a/b to 0
module gate_check_seq
  import gate_check_seq_pkg::*;
#(
  parameter int HOLD_CYCLES = 4,
  parameter int CNT_W       = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       abort,
  input  logic [2:0] op,
  input  logic       y_i,
  output logic       a_o,
  output logic       b_o,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [2:0] err_cnt,
  output logic [3:0] fail_map,
  output logic       cfg_err
);

  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       vec_q, vec_d;
  logic [2:0]       op_q, op_d;
  logic             a_q, a_d, b_q, b_d;
  logic             pass_q, pass_d;
  logic [2:0]       err_q, err_d;
  logic [3:0]       map_q, map_d;
  logic             cfg_err_q, cfg_err_d;
  logic             exp_y;

  gate_ref_model u_ref (
    .op (op_q),
    .a  (a_q),
    .b  (b_q),
    .y  (exp_y)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      vec_q     <= '0;
      op_q      <= '0;
      a_q       <= 1'b0;
      b_q       <= 1'b0;
      pass_q    <= 1'b0;
      err_q     <= '0;
      map_q     <= '0;
      cfg_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      vec_q     <= vec_d;
      op_q      <= op_d;
      a_q       <= a_d;
      b_q       <= b_d;
      pass_q    <= pass_d;
      err_q     <= err_d;
      map_q     <= map_d;
      cfg_err_q <= cfg_err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    vec_d     = vec_q;
    op_d      = op_q;
    a_d       = a_q;
    b_d       = b_q;
    pass_d    = pass_q;
    err_d     = err_q;
    map_d     = map_q;
    cfg_err_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start && !abort) begin
          if (op <= OP_LAST) begin
            op_d    = op;
            err_d   = '0;
            map_d   = '0;
            pass_d  = 1'b0;
            vec_d   = '0;
            state_d = ST_APPLY;
          end else begin
            cfg_err_d = 1'b1;
          end
        end
      end
      ST_APPLY: begin
        a_d     = vec_q[1];
        b_d     = vec_q[0];
        cnt_d   = HOLD_LOAD;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (cnt_q == '0) state_d = ST_SAMPLE;
        else             cnt_d   = cnt_q - 1'b1;
      end
      ST_SAMPLE: begin
        if (y_i != exp_y) begin
          err_d        = err_q + 3'd1;
          map_d[vec_q] = 1'b1;
        end
        // Publish pass together with the done pulse rather than a cycle later.
        if (vec_q == LAST_VEC) begin
          pass_d  = (err_d == '0);
          state_d = ST_DONE;
        end else begin
          vec_d   = vec_q + 2'd1;
          state_d = ST_APPLY;
        end
      end
      ST_DONE: begin
        a_d     = 1'b0;
        b_d     = 1'b0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (abort && state_q != ST_IDLE) begin
      state_d = ST_IDLE;
      a_d     = 1'b0;
      b_d     = 1'b0;
      pass_d  = 1'b0;
    end
  end

  assign a_o      = a_q;
  assign b_o      = b_q;
  assign busy     = (state_q != ST_IDLE);
  assign done     = (state_q == ST_DONE);
  assign pass     = pass_q;
  assign err_cnt  = err_q;
  assign fail_map = map_q;
  assign cfg_err  = cfg_err_q;

endmodule

// File: tb/tb_gate_check_seq.sv
// Directed bench for gate_check_seq: table of (op, attached gate) runs with
// hand-computed results, plus cfg_err, abort and mid-run reset sequences.
module tb_gate_check_seq;

  localparam int HOLD = 4;
  localparam int LAT  = 4 * (HOLD + 2);

  // Kinds of gate the bench can attach to y_i.
  localparam logic [2:0] G_AND = 3'd0, G_OR = 3'd1, G_XOR = 3'd2, G_NAND = 3'd3,
                         G_NOR = 3'd4, G_XNOR = 3'd5, G_ONE = 3'd6, G_ZERO = 3'd7;

  typedef struct {
    logic [2:0] op;
    logic [2:0] gate;
    int         err;
    logic [3:0] map;
    logic       pass;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [2:0] op = 3'd0;
  logic [2:0] gate_sel = G_XOR;
  logic       y_i;
  logic       a_o, b_o, busy, done, pass, cfg_err;
  logic [2:0] err_cnt;
  logic [3:0] fail_map;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  function automatic logic attached_gate(input logic [2:0] kind, input logic a, input logic b);
    case (kind)
      G_AND:   return a & b;
      G_OR:    return a | b;
      G_XOR:   return a ^ b;
      G_NAND:  return ~(a & b);
      G_NOR:   return ~(a | b);
      G_XNOR:  return ~(a ^ b);
      G_ONE:   return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  assign y_i = attached_gate(gate_sel, a_o, b_o);

  gate_check_seq #(.HOLD_CYCLES(HOLD), .CNT_W(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .abort    (abort),
    .op       (op),
    .y_i      (y_i),
    .a_o      (a_o),
    .b_o      (b_o),
    .busy     (busy),
    .done     (done),
    .pass     (pass),
    .err_cnt  (err_cnt),
    .fail_map (fail_map),
    .cfg_err  (cfg_err)
  );

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " a_o"}, int'(a_o), 0);
    check({tag, " b_o"}, int'(b_o), 0);
    check({tag, " busy"}, int'(busy), 0);
    check({tag, " done"}, int'(done), 0);
    check({tag, " pass"}, int'(pass), 0);
    check({tag, " err_cnt"}, int'(err_cnt), 0);
    check({tag, " fail_map"}, int'(fail_map), 0);
    check({tag, " cfg_err"}, int'(cfg_err), 0);
  endtask

  // Pulse start for one cycle and follow the run to its done pulse.
  task automatic run_vec(input vec_t v, input string tag);
    int lat;
    lat = -1;
    @(negedge clk);
    op = v.op; gate_sel = v.gate; start = 1'b1;
    @(posedge clk); #1;
    check({tag, " busy after start"}, int'(busy), 1);
    @(negedge clk);
    start = 1'b0;
    for (int n = 1; n <= 60; n++) begin
      @(posedge clk); #1;
      if (n % (HOLD + 2) == 3 && n < LAT)
        check({tag, " ab vector"}, int'({a_o, b_o}), n / (HOLD + 2));
      if (done) begin
        lat = n;
        break;
      end
    end
    check({tag, " done latency"}, lat, LAT);
    check({tag, " err_cnt"}, int'(err_cnt), v.err);
    check({tag, " fail_map"}, int'(fail_map), int'(v.map));
    check({tag, " pass"}, int'(pass), int'(v.pass));
    @(posedge clk); #1;
    check({tag, " ab cleared"}, int'({a_o, b_o}), 0);
    check({tag, " busy after done"}, int'(busy), 0);
    check({tag, " done single"}, int'(done), 0);
    check({tag, " pass held"}, int'(pass), int'(v.pass));
  endtask

  vec_t vecs[8];

  initial begin
    int dones;
    int lat;

    vecs[0] = '{op: 3'd2, gate: G_XOR,  err: 0, map: 4'b0000, pass: 1'b1};
    vecs[1] = '{op: 3'd0, gate: G_XOR,  err: 3, map: 4'b1110, pass: 1'b0};
    vecs[2] = '{op: 3'd5, gate: G_ONE,  err: 2, map: 4'b0110, pass: 1'b0};
    vecs[3] = '{op: 3'd1, gate: G_OR,   err: 0, map: 4'b0000, pass: 1'b1};
    vecs[4] = '{op: 3'd3, gate: G_AND,  err: 4, map: 4'b1111, pass: 1'b0};
    vecs[5] = '{op: 3'd4, gate: G_ZERO, err: 1, map: 4'b0001, pass: 1'b0};
    vecs[6] = '{op: 3'd0, gate: G_AND,  err: 0, map: 4'b0000, pass: 1'b1};
    vecs[7] = '{op: 3'd3, gate: G_NAND, err: 0, map: 4'b0000, pass: 1'b1};

    #12;
    check_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Reserved op: cfg_err pulse only; last pass (vec7 = 1) must survive.
    @(negedge clk);
    op = 3'd6; start = 1'b1;
    @(posedge clk); #1;
    check("cfg_err pulse", int'(cfg_err), 1);
    check("cfg_err busy", int'(busy), 0);
    @(negedge clk);
    start = 1'b0;
    @(posedge clk); #1;
    check("cfg_err one cycle", int'(cfg_err), 0);
    dones = 0;
    for (int n = 0; n < 10; n++) begin
      @(posedge clk); #1;
      if (done || busy) dones++;
    end
    check("cfg_err no run", dones, 0);
    check("cfg_err pass kept", int'(pass), 1);

    // abort together with start in IDLE: abort wins.
    @(negedge clk);
    op = 3'd2; start = 1'b1; abort = 1'b1;
    @(posedge clk); #1;
    check("abort+start busy", int'(busy), 0);
    @(negedge clk);
    start = 1'b0; abort = 1'b0;

    // Abort in WAIT of vector 2 with op AND against XOR gate (vector 1 failed).
    @(negedge clk);
    op = 3'd0; gate_sel = G_XOR; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    for (int n = 1; n <= 14; n++) @(posedge clk);
    #1;
    check("abort pre ab", int'({a_o, b_o}), 2);
    @(negedge clk);
    abort = 1'b1;
    @(posedge clk); #1;
    check("abort busy", int'(busy), 0);
    check("abort done", int'(done), 0);
    check("abort ab", int'({a_o, b_o}), 0);
    check("abort pass", int'(pass), 0);
    check("abort err_cnt kept", int'(err_cnt), 1);
    check("abort fail_map kept", int'(fail_map), 2);
    @(negedge clk);
    abort = 1'b0;
    dones = 0;
    for (int n = 0; n < 30; n++) begin
      @(posedge clk); #1;
      if (done) dones++;
    end
    check("abort no done", dones, 0);
    run_vec(vecs[0], "post-abort");

    // Reset during SAMPLE of vector 3 (op AND, XOR gate: err 2 so far).
    @(negedge clk);
    op = 3'd0; gate_sel = G_XOR; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    for (int n = 1; n <= LAT - 1; n++) @(posedge clk);
    #1;
    check("pre-reset err_cnt", int'(err_cnt), 2);
    check("pre-reset busy", int'(busy), 1);
    rst_n = 1'b0;
    #1;
    check_all_zero("async reset");

    // Start held high through a whole run: exactly one run.
    @(negedge clk);
    rst_n = 1'b1; op = 3'd2; gate_sel = G_XOR; start = 1'b1;
    @(posedge clk);
    lat = -1;
    for (int n = 1; n <= 60; n++) begin
      @(posedge clk); #1;
      if (done) begin
        lat = n;
        break;
      end
    end
    check("held-start latency", lat, LAT);
    check("held-start pass", int'(pass), 1);
    @(negedge clk);
    start = 1'b0;
    dones = 0;
    for (int n = 0; n < 30; n++) begin
      @(posedge clk); #1;
      if (done) dones++;
    end
    check("held-start single done", dones, 0);
    check("held-start idle", int'(busy), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
